// File: rtl/irig_frame_sync.sv
// IRIG-B frame synchroniser: hunts for the Pr marker, tracks frame
// position 0..99 and emits per-bit field strobes plus a frame-complete pulse.
module irig_frame_sync #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       symbol_valid,
  input  logic [1:0] symbol,
  output logic [2:0] ts_select,
  output logic       ts_finish,
  output logic [4:0] bit_idx,
  output logic [1:0] digit_idx,
  output logic       bit_value,
  output logic       locked,
  output logic       frame_start,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_ONE  = CW'(1);
  localparam logic [CW-1:0] TMO_ZERO = '0;

  localparam logic [1:0] SYM_ZERO = 2'd0;
  localparam logic [1:0] SYM_ONE  = 2'd1;
  localparam logic [1:0] SYM_MARK = 2'd2;

  localparam logic [2:0] SEL_IDLE = 3'd0;
  localparam logic [2:0] SEL_SEC  = 3'd1;
  localparam logic [2:0] SEL_MIN  = 3'd2;
  localparam logic [2:0] SEL_HOUR = 3'd3;
  localparam logic [2:0] SEL_DAY  = 3'd4;
  localparam logic [2:0] SEL_YEAR = 3'd5;
  localparam logic [2:0] SEL_SBS  = 3'd6;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      pos_q, pos_d;
  logic            mark_seen_q, mark_seen_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [2:0]      ts_select_q, ts_select_d;
  logic            ts_finish_q, ts_finish_d;
  logic [4:0]      bit_idx_q, bit_idx_d;
  logic [1:0]      digit_idx_q, digit_idx_d;
  logic            bit_value_q, bit_value_d;
  logic            locked_q, locked_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_err_q, frame_err_d;

  logic [6:0]      pos_n;
  logic            mark_pos;
  logic            sym_ok;
  logic [2:0]      fld_sel;
  logic [1:0]      fld_dig;
  logic [4:0]      fld_bit;

  function automatic logic in_rng(
    input logic [6:0] p,
    input logic [6:0] lo,
    input logic [6:0] hi
  );
    return (p >= lo) && (p <= hi);
  endfunction

  // Everything is evaluated against the position the incoming symbol will occupy.
  always_comb begin
    pos_n    = (pos_q == 7'd99) ? 7'd0 : pos_q + 7'd1;
    mark_pos = (pos_n == 7'd0) || ((pos_n % 7'd10) == 7'd9);
    if (mark_pos) begin
      sym_ok = (symbol == SYM_MARK);
    end else begin
      sym_ok = (symbol == SYM_ZERO) || (symbol == SYM_ONE);
    end
  end

  always_comb begin
    fld_sel = SEL_IDLE;
    fld_dig = 2'd0;
    fld_bit = 5'd0;
    unique case (1'b1)
      in_rng(pos_n, 7'd1, 7'd4): begin
        fld_sel = SEL_SEC;
        fld_bit = 5'(pos_n - 7'd1);
      end
      in_rng(pos_n, 7'd6, 7'd8): begin
        fld_sel = SEL_SEC;
        fld_dig = 2'd1;
        fld_bit = 5'(pos_n - 7'd6);
      end
      in_rng(pos_n, 7'd10, 7'd13): begin
        fld_sel = SEL_MIN;
        fld_bit = 5'(pos_n - 7'd10);
      end
      in_rng(pos_n, 7'd15, 7'd17): begin
        fld_sel = SEL_MIN;
        fld_dig = 2'd1;
        fld_bit = 5'(pos_n - 7'd15);
      end
      in_rng(pos_n, 7'd20, 7'd23): begin
        fld_sel = SEL_HOUR;
        fld_bit = 5'(pos_n - 7'd20);
      end
      in_rng(pos_n, 7'd25, 7'd26): begin
        fld_sel = SEL_HOUR;
        fld_dig = 2'd1;
        fld_bit = 5'(pos_n - 7'd25);
      end
      in_rng(pos_n, 7'd30, 7'd33): begin
        fld_sel = SEL_DAY;
        fld_bit = 5'(pos_n - 7'd30);
      end
      in_rng(pos_n, 7'd35, 7'd38): begin
        fld_sel = SEL_DAY;
        fld_dig = 2'd1;
        fld_bit = 5'(pos_n - 7'd35);
      end
      in_rng(pos_n, 7'd40, 7'd41): begin
        fld_sel = SEL_DAY;
        fld_dig = 2'd2;
        fld_bit = 5'(pos_n - 7'd40);
      end
      in_rng(pos_n, 7'd50, 7'd53): begin
        fld_sel = SEL_YEAR;
        fld_bit = 5'(pos_n - 7'd50);
      end
      in_rng(pos_n, 7'd55, 7'd58): begin
        fld_sel = SEL_YEAR;
        fld_dig = 2'd1;
        fld_bit = 5'(pos_n - 7'd55);
      end
      in_rng(pos_n, 7'd80, 7'd88): begin
        fld_sel = SEL_SBS;
        fld_bit = 5'(pos_n - 7'd80);
      end
      // Marker at 89 splits the straight-binary field; bits continue at 9.
      in_rng(pos_n, 7'd90, 7'd97): begin
        fld_sel = SEL_SBS;
        fld_bit = 5'(pos_n - 7'd81);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    mark_seen_d   = mark_seen_q;
    tmo_d         = tmo_q;
    ts_select_d   = SEL_IDLE;
    ts_finish_d   = 1'b0;
    bit_idx_d     = bit_idx_q;
    digit_idx_d   = digit_idx_q;
    bit_value_d   = bit_value_q;
    frame_start_d = 1'b0;
    frame_err_d   = 1'b0;

    unique case (state_q)
      HUNT: begin
        tmo_d = TMO_ZERO;
        if (symbol_valid) begin
          if (symbol == SYM_MARK) begin
            if (mark_seen_q) begin
              state_d       = LOCKED;
              pos_d         = 7'd0;
              mark_seen_d   = 1'b0;
              frame_start_d = 1'b1;
            end else begin
              mark_seen_d = 1'b1;
            end
          end else begin
            mark_seen_d = 1'b0;
          end
        end
      end
      LOCKED: begin
        if (symbol_valid) begin
          tmo_d = TMO_ZERO;
          if (sym_ok) begin
            pos_d         = pos_n;
            ts_finish_d   = (pos_n == 7'd99);
            frame_start_d = (pos_n == 7'd0);
            if (fld_sel != SEL_IDLE && !ts_finish_q) begin
              ts_select_d = fld_sel;
              digit_idx_d = fld_dig;
              bit_idx_d   = fld_bit;
              bit_value_d = (symbol == SYM_ONE);
            end
          end else begin
            // A stray MARK may be the first half of the next Pr.
            state_d     = HUNT;
            pos_d       = 7'd0;
            mark_seen_d = (symbol == SYM_MARK);
            frame_err_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d     = HUNT;
          pos_d       = 7'd0;
          mark_seen_d = 1'b0;
          tmo_d       = TMO_ZERO;
          frame_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      default: ;
    endcase

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      pos_q         <= 7'd0;
      mark_seen_q   <= 1'b0;
      tmo_q         <= TMO_ZERO;
      ts_select_q   <= SEL_IDLE;
      ts_finish_q   <= 1'b0;
      bit_idx_q     <= 5'd0;
      digit_idx_q   <= 2'd0;
      bit_value_q   <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      mark_seen_q   <= mark_seen_d;
      tmo_q         <= tmo_d;
      ts_select_q   <= ts_select_d;
      ts_finish_q   <= ts_finish_d;
      bit_idx_q     <= bit_idx_d;
      digit_idx_q   <= digit_idx_d;
      bit_value_q   <= bit_value_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign ts_select   = ts_select_q;
  assign ts_finish   = ts_finish_q;
  assign bit_idx     = bit_idx_q;
  assign digit_idx   = digit_idx_q;
  assign bit_value   = bit_value_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign frame_err   = frame_err_q;

endmodule
